// File: rtl/mul_share_ctrl_pkg.sv
// Shared types and defaults for the shared-multiplier controller.
// Imported by the controller top and its round-robin arbiter.
package mul_pkg;

    localparam int W_A_DEF = 11;
    localparam int W_B_DEF = 11;
    localparam int W_P_DEF = W_A_DEF + W_B_DEF;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        RESP
    } state_t;

    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: first request at or above ptr, wrapping.
// Returns the grant both one-hot and as an index.
module rr_arbiter
    import mul_pkg::*;
#(
    parameter int N_REQ = 2,
    localparam int IW = idx_w(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IW-1:0]    ptr,
    output logic [N_REQ-1:0] grant,
    output logic [IW-1:0]    grant_idx
);

    logic found;

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        for (int k = 0; k < N_REQ; k++) begin
            if (!found && req[(int'(ptr) + k) % N_REQ]) begin
                found = 1'b1;
                grant[(int'(ptr) + k) % N_REQ] = 1'b1;
                grant_idx = IW'((int'(ptr) + k) % N_REQ);
            end
        end
    end

endmodule

// File: rtl/mul_share_ctrl.sv
// Shares one multi-cycle multiplier between N_REQ requesters with
// round-robin arbitration, one op in flight and a watchdog abort.
module mul_share_ctrl
    import mul_pkg::*;
#(
    parameter int W_A   = W_A_DEF,
    parameter int W_B   = W_B_DEF,
    parameter int N_REQ = 2,
    parameter int W_TO  = 16,
    localparam int W_P  = W_A + W_B,
    localparam int IW   = idx_w(N_REQ)
) (
    input  logic               clock,
    input  logic               reset,
    input  logic [N_REQ-1:0]   req_valid,
    output logic [N_REQ-1:0]   req_ready,
    input  logic [N_REQ*W_A-1:0] req_a,
    input  logic [N_REQ*W_B-1:0] req_b,
    output logic [N_REQ-1:0]   rsp_valid,
    input  logic [N_REQ-1:0]   rsp_ready,
    output logic [W_P-1:0]     rsp_product,
    output logic               rsp_err,
    output logic               mul_start,
    output logic [W_A-1:0]     mul_a,
    output logic [W_B-1:0]     mul_b,
    input  logic               mul_done,
    input  logic [W_P-1:0]     mul_product,
    output logic               busy
);

    // Leaving WAIT when the counter steps onto all-ones bounds WAIT
    // to 2**W_TO-1 cycles.
    localparam logic [W_TO-1:0] WD_LAST = {{(W_TO-1){1'b1}}, 1'b0};

    state_t            state;
    logic [IW-1:0]     rr_ptr;
    logic [IW-1:0]     owner;
    logic [IW-1:0]     gnt_idx;
    logic [N_REQ-1:0]  gnt;
    logic [W_TO-1:0]   wd;
    logic              done_ok;
    logic              to_hit;

    rr_arbiter #(.N_REQ(N_REQ)) u_arb (
        .req       (req_valid),
        .ptr       (rr_ptr),
        .grant     (gnt),
        .grant_idx (gnt_idx)
    );

    // wd is zero only in the first WAIT cycle, where done may be stale.
    assign done_ok   = mul_done && (wd != '0);
    assign to_hit    = (wd == WD_LAST);
    assign req_ready = (state == IDLE && reset) ? gnt : '0;
    assign rsp_valid = (state == RESP) ? (N_REQ'(1) << owner) : '0;
    assign mul_start = (state == ISSUE);
    assign busy      = (state != IDLE);

    always_ff @(posedge clock) begin
        if (!reset) begin
            state       <= IDLE;
            rr_ptr      <= '0;
            owner       <= '0;
            wd          <= '0;
            mul_a       <= '0;
            mul_b       <= '0;
            rsp_product <= '0;
            rsp_err     <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (|req_valid) begin
                        mul_a <= req_a[int'(gnt_idx)*W_A +: W_A];
                        mul_b <= req_b[int'(gnt_idx)*W_B +: W_B];
                        owner <= gnt_idx;
                        state <= ISSUE;
                    end
                end
                ISSUE: begin
                    wd    <= '0;
                    state <= WAIT;
                end
                WAIT: begin
                    wd <= wd + 1'b1;
                    if (done_ok) begin
                        rsp_product <= mul_product;
                        rsp_err     <= 1'b0;
                        state       <= RESP;
                    end else if (to_hit) begin
                        rsp_product <= '0;
                        rsp_err     <= 1'b1;
                        state       <= RESP;
                    end
                end
                RESP: begin
                    if (rsp_ready[owner]) begin
                        rr_ptr <= (owner == IW'(N_REQ-1)) ? '0 : owner + 1'b1;
                        state  <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mul_share_ctrl.sv
// Scoreboard bench for mul_share_ctrl with a behavioural multiplier.
// Expected responses are queued when requests are driven.
module tb_mul_share_ctrl;

    logic        clock = 1'b0;
    logic        reset;
    logic [1:0]  req_valid;
    logic [1:0]  req_ready;
    logic [21:0] req_a;
    logic [21:0] req_b;
    logic [1:0]  rsp_valid;
    logic [1:0]  rsp_ready;
    logic [21:0] rsp_product;
    logic        rsp_err;
    logic        mul_start;
    logic [10:0] mul_a;
    logic [10:0] mul_b;
    logic        mul_done = 1'b0;
    logic [21:0] mul_product = '0;
    logic        busy;

    typedef struct {
        logic [1:0]  own;
        logic [21:0] prod;
        logic        err;
    } exp_t;

    exp_t sbq[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    int lat   = 3;
    bit stuck = 1'b0;
    bit hang  = 1'b0;
    bit pend  = 1'b0;
    int mcnt  = 0;

    always #5 clock = ~clock;

    mul_share_ctrl #(.W_A(11), .W_B(11), .N_REQ(2), .W_TO(4)) dut (
        .clock       (clock),
        .reset       (reset),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_a       (req_a),
        .req_b       (req_b),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_product (rsp_product),
        .rsp_err     (rsp_err),
        .mul_start   (mul_start),
        .mul_a       (mul_a),
        .mul_b       (mul_b),
        .mul_done    (mul_done),
        .mul_product (mul_product),
        .busy        (busy)
    );

    function automatic logic [21:0] ref_mul(input logic [10:0] a, input logic [10:0] b);
        logic signed [21:0] x;
        logic signed [21:0] y;
        x = $signed(a);
        y = $signed(b);
        return x * y;
    endfunction

    // Multiplier model: done pulses (or sticks high) lat cycles after start.
    always @(posedge clock) begin
        if (mul_start) begin
            pend <= 1'b1;
            mcnt <= lat;
            if (!stuck) mul_done <= 1'b0;
        end else if (pend && !hang && mcnt <= 1) begin
            pend        <= 1'b0;
            mul_done    <= 1'b1;
            mul_product <= ref_mul(mul_a, mul_b);
        end else begin
            if (pend && !hang) mcnt <= mcnt - 1;
            if (!stuck) mul_done <= 1'b0;
        end
    end

    task automatic do_reset();
        reset = 1'b0;
        req_valid = '0;
        rsp_ready = '0;
        repeat (3) @(negedge clock);
        reset = 1'b1;
    endtask

    task automatic issue_req(input int i, input logic [10:0] a,
                             input logic [10:0] b, output bit got);
        int t;
        req_valid[i] = 1'b1;
        req_a[i*11 +: 11] = a;
        req_b[i*11 +: 11] = b;
        #1;
        t = 0;
        while (!req_ready[i] && t < 50) begin
            @(negedge clock);
            #1;
            t++;
        end
        got = req_ready[i];
        @(posedge clock);
        #1;
        req_valid[i] = 1'b0;
        @(negedge clock);
    endtask

    task automatic get_rsp(output bit ok, output logic [1:0] v,
                           output logic [21:0] p, output logic e);
        int t;
        t = 0;
        while (rsp_valid == '0 && t < 300) begin
            @(negedge clock);
            t++;
        end
        ok = (rsp_valid != '0);
        v = rsp_valid;
        p = rsp_product;
        e = rsp_err;
        if (ok) begin
            rsp_ready = v;
            @(negedge clock);
            rsp_ready = '0;
        end
    endtask

    task automatic test_reset();
        req_a = '0;
        req_b = '0;
        do_reset();
        reset = 1'b0;
        req_valid = 2'b11;
        #1;
        n_cmp++;
        if ({req_ready, rsp_valid, mul_start, busy, rsp_err} !== 7'b0) begin
            n_bad++;
            $display("FAIL reset_ctl: got %b want 0",
                     {req_ready, rsp_valid, mul_start, busy, rsp_err});
        end
        n_cmp++;
        if ({mul_a, mul_b, rsp_product} !== 44'b0) begin
            n_bad++;
            $display("FAIL reset_data: got %h want 0", {mul_a, mul_b, rsp_product});
        end
        req_valid = '0;
        reset = 1'b1;
        @(negedge clock);
    endtask

    task automatic test_single();
        bit ok;
        logic [1:0] v;
        logic [21:0] p;
        logic e;
        exp_t x;
        lat = 12;
        sbq.push_back('{2'b01, 22'h3FFFF1, 1'b0});
        issue_req(0, 11'd3, 11'h7FB, ok);
        n_cmp++;
        if (ok !== 1'b1) begin
            n_bad++;
            $display("FAIL t1_ready: got %0b want 1", ok);
        end
        n_cmp++;
        if ({mul_start, busy, mul_a, mul_b} !== {2'b11, 11'd3, 11'h7FB}) begin
            n_bad++;
            $display("FAIL t1_issue: got %b %b %h %h want 1 1 003 7fb",
                     mul_start, busy, mul_a, mul_b);
        end
        get_rsp(ok, v, p, e);
        x = sbq.pop_front();
        n_cmp++;
        if ({ok, v, p, e} !== {1'b1, x.own, x.prod, x.err}) begin
            n_bad++;
            $display("FAIL t1_rsp: got ok=%0b v=%b p=%h e=%b want v=%b p=%h e=%b",
                     ok, v, p, e, x.own, x.prod, x.err);
        end
    endtask

    task automatic test_round_robin();
        logic [10:0] ta[4] = '{11'h400, 11'd1023, 11'h7FF, 11'd127};
        logic [10:0] tb[4] = '{11'h400, 11'h400, 11'd1, 11'd33};
        logic [1:0] g;
        bit ok;
        logic [1:0] v;
        logic [21:0] p;
        logic e;
        exp_t x;
        int t;
        int k;
        lat = 3;
        do_reset();
        req_a = {ta[1], ta[0]};
        req_b = {tb[1], tb[0]};
        req_valid = 2'b11;
        for (int op = 0; op < 4; op++) begin
            #1;
            t = 0;
            while (req_ready == '0 && t < 50) begin
                @(negedge clock);
                #1;
                t++;
            end
            g = 2'b01 << (op % 2);
            n_cmp++;
            if (req_ready !== g) begin
                n_bad++;
                $display("FAIL t2_grant%0d: got %b want %b", op, req_ready, g);
            end
            k = (op % 2 == 0) ? 0 : 1;
            sbq.push_back('{g, ref_mul(req_a[k*11 +: 11], req_b[k*11 +: 11]), 1'b0});
            @(posedge clock);
            #1;
            if (op + 2 < 4) begin
                req_a[k*11 +: 11] = ta[op + 2];
                req_b[k*11 +: 11] = tb[op + 2];
            end
            @(negedge clock);
            get_rsp(ok, v, p, e);
            x = sbq.pop_front();
            n_cmp++;
            if ({ok, v, p, e} !== {1'b1, x.own, x.prod, x.err}) begin
                n_bad++;
                $display("FAIL t2_rsp%0d: got v=%b p=%h e=%b want v=%b p=%h e=%b",
                         op, v, p, e, x.own, x.prod, x.err);
            end
        end
        req_valid = '0;
    endtask

    task automatic test_hold();
        bit ok;
        logic [1:0] v;
        logic [21:0] p;
        logic e;
        exp_t x;
        int t;
        int badc;
        lat = 4;
        sbq.push_back('{2'b10, ref_mul(11'h7F0, 11'd100), 1'b0});
        issue_req(1, 11'h7F0, 11'd100, ok);
        t = 0;
        while (rsp_valid == '0 && t < 100) begin
            @(negedge clock);
            t++;
        end
        v = rsp_valid;
        p = rsp_product;
        req_valid[0] = 1'b1;
        req_a[10:0] = 11'd5;
        req_b[10:0] = 11'd6;
        rsp_ready = 2'b01;
        badc = 0;
        repeat (10) begin
            @(negedge clock);
            if (rsp_valid !== v || rsp_product !== p || mul_start !== 1'b0 || busy !== 1'b1)
                badc++;
        end
        n_cmp++;
        if (badc !== 0 || v !== 2'b10) begin
            n_bad++;
            $display("FAIL t3_hold: got %0d unstable cycles v=%b want 0 v=10", badc, v);
        end
        rsp_ready = 2'b10;
        @(negedge clock);
        rsp_ready = '0;
        x = sbq.pop_front();
        n_cmp++;
        if (p !== x.prod) begin
            n_bad++;
            $display("FAIL t3_prod: got %h want %h", p, x.prod);
        end
        sbq.push_back('{2'b01, 22'd30, 1'b0});
        #1;
        n_cmp++;
        if (req_ready !== 2'b01) begin
            n_bad++;
            $display("FAIL t3_next_grant: got %b want 01", req_ready);
        end
        @(posedge clock);
        #1;
        req_valid = '0;
        get_rsp(ok, v, p, e);
        x = sbq.pop_front();
        n_cmp++;
        if ({ok, v, p, e} !== {1'b1, x.own, x.prod, x.err}) begin
            n_bad++;
            $display("FAIL t3_next_rsp: got v=%b p=%h e=%b want v=%b p=%h e=%b",
                     v, p, e, x.own, x.prod, x.err);
        end
    endtask

    task automatic test_timeout();
        bit ok;
        logic [1:0] v;
        logic [21:0] p;
        logic e;
        exp_t x;
        int t;
        hang = 1'b1;
        sbq.push_back('{2'b01, 22'd0, 1'b1});
        issue_req(0, 11'd9, 11'd9, ok);
        t = 0;
        while (rsp_valid == '0 && t < 40) begin
            @(negedge clock);
            t++;
        end
        n_cmp++;
        if (t !== 16) begin
            n_bad++;
            $display("FAIL t4_latency: got %0d cycles after issue want 16", t);
        end
        get_rsp(ok, v, p, e);
        x = sbq.pop_front();
        n_cmp++;
        if ({ok, v, p, e} !== {1'b1, x.own, x.prod, x.err}) begin
            n_bad++;
            $display("FAIL t4_abort: got v=%b p=%h e=%b want v=%b p=%h e=%b",
                     v, p, e, x.own, x.prod, x.err);
        end
        hang = 1'b0;
        lat = 3;
        sbq.push_back('{2'b10, 22'd15, 1'b0});
        issue_req(1, 11'h7FD, 11'h7FB, ok);
        get_rsp(ok, v, p, e);
        x = sbq.pop_front();
        n_cmp++;
        if ({ok, v, p, e} !== {1'b1, x.own, x.prod, x.err}) begin
            n_bad++;
            $display("FAIL t4_recover: got v=%b p=%h e=%b want v=%b p=%h e=%b",
                     v, p, e, x.own, x.prod, x.err);
        end
    endtask

    task automatic test_stale_done();
        bit ok;
        logic [1:0] v;
        logic [21:0] p;
        logic e;
        exp_t x;
        int t;
        stuck = 1'b1;
        lat = 5;
        sbq.push_back('{2'b01, 22'd63, 1'b0});
        issue_req(0, 11'd7, 11'd9, ok);
        get_rsp(ok, v, p, e);
        x = sbq.pop_front();
        n_cmp++;
        if ({ok, v, p, e} !== {1'b1, x.own, x.prod, x.err}) begin
            n_bad++;
            $display("FAIL t5_first: got v=%b p=%h e=%b want v=%b p=%h", v, p, e, x.own, x.prod);
        end
        lat = 1;
        sbq.push_back('{2'b10, ref_mul(11'h7FE, 11'd100), 1'b0});
        issue_req(1, 11'h7FE, 11'd100, ok);
        t = 0;
        while (rsp_valid == '0 && t < 40) begin
            @(negedge clock);
            t++;
        end
        n_cmp++;
        if (t !== 3) begin
            n_bad++;
            $display("FAIL t5_latency: got %0d cycles after issue want 3", t);
        end
        get_rsp(ok, v, p, e);
        x = sbq.pop_front();
        n_cmp++;
        if ({ok, v, p, e} !== {1'b1, x.own, x.prod, x.err}) begin
            n_bad++;
            $display("FAIL t5_stale: got v=%b p=%h e=%b want v=%b p=%h", v, p, e, x.own, x.prod);
        end
        stuck = 1'b0;
        @(negedge clock);
    endtask

    task automatic test_reset_mid();
        bit ok;
        logic [1:0] v;
        logic [21:0] p;
        logic e;
        exp_t x;
        int badc;
        lat = 3;
        sbq.push_back('{2'b01, 22'd12, 1'b0});
        issue_req(0, 11'd3, 11'd4, ok);
        get_rsp(ok, v, p, e);
        x = sbq.pop_front();
        n_cmp++;
        if ({ok, v, p, e} !== {1'b1, x.own, x.prod, x.err}) begin
            n_bad++;
            $display("FAIL t6_pre: got v=%b p=%h want v=%b p=%h", v, p, x.own, x.prod);
        end
        lat = 8;
        issue_req(1, 11'd10, 11'd10, ok);
        repeat (2) @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        n_cmp++;
        if ({req_ready, rsp_valid, mul_start, busy, rsp_err, mul_a, mul_b, rsp_product} !== 51'b0) begin
            n_bad++;
            $display("FAIL t6_reset: got busy=%b start=%b rsp=%b a=%h b=%h p=%h want 0",
                     busy, mul_start, rsp_valid, mul_a, mul_b, rsp_product);
        end
        reset = 1'b1;
        badc = 0;
        repeat (20) begin
            @(negedge clock);
            if (rsp_valid !== 2'b00 || busy !== 1'b0) badc++;
        end
        n_cmp++;
        if (badc !== 0) begin
            n_bad++;
            $display("FAIL t6_late_done: got %0d active cycles want 0", badc);
        end
        lat = 3;
        req_a = {11'd2, 11'd6};
        req_b = {11'd2, 11'h7F9};
        req_valid = 2'b11;
        #1;
        n_cmp++;
        if (req_ready !== 2'b01) begin
            n_bad++;
            $display("FAIL t6_ptr: got %b want 01", req_ready);
        end
        sbq.push_back('{2'b01, ref_mul(11'd6, 11'h7F9), 1'b0});
        @(posedge clock);
        #1;
        req_valid = '0;
        get_rsp(ok, v, p, e);
        x = sbq.pop_front();
        n_cmp++;
        if ({ok, v, p, e} !== {1'b1, x.own, x.prod, x.err}) begin
            n_bad++;
            $display("FAIL t6_post: got v=%b p=%h e=%b want v=%b p=%h", v, p, e, x.own, x.prod);
        end
    endtask

    initial begin
        reset = 1'b0;
        req_valid = '0;
        rsp_ready = '0;
        req_a = '0;
        req_b = '0;
        test_reset();
        test_single();
        test_round_robin();
        test_hold();
        test_timeout();
        test_stale_done();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: got no completion want finish");
        $fatal(1, "bench timeout");
    end

endmodule
